regfile_dump: RTL and testbench

- Debug read-out engine that sits on a dedicated read port of the processor register file.
- On command, it walks a register range and presents each register word on a valid/ready output stream, with its index and a last flag.
- It feeds the debug/trace path: it is the reader side of the register file's address/read-data interface.

---
 rtl/regfile_dump.sv | 150 +++++++++++++++
 tb/tb_regfile_dump.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: debug read-out engine on a dedicated register-file read port.
// On an accepted start it walks the register range first..last, wrapping past
// Depth-1 to 0 if needed. It presents each word on a valid/ready stream
// together with its index and a last flag.
//
// Ports:
//   CLK      rising-edge clock
//   reset    asynchronous, active-low reset
//   start    one-cycle dump request (honoured in IDLE only)
//   abort    synchronous cancel of a dump in progress
//   first    first register index of the range (sampled with start)
//   last     final register index of the range (sampled with start)
//   rf_addr  register-file read address (valid in LOAD, 0 otherwise)
//   rf_data  combinational register-file read data for rf_addr
//   m_valid  output word valid
//   m_ready  downstream accepts word
//   m_data   register contents
//   m_index  register index of m_data
//   m_last   final word of the dump
//   busy     high from the cycle after an accepted start until back in IDLE
//   done     one-cycle pulse after the final word is accepted
//   err      one-cycle pulse when start is rejected for an out-of-range index
module regfile_dump #(
  parameter int Depth = 32,
  parameter int Width = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [4:0]       first,
  input  logic [4:0]       last,
  output logic [4:0]       rf_addr,
  input  logic [Width-1:0] rf_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [Width-1:0] m_data,
  output logic [4:0]       m_index,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Depth compared in 6 bits so that Depth=32 needs no special case.
  localparam logic [5:0] DEPTH_CNT = 6'(Depth);
  localparam logic [4:0] TOP_IDX   = 5'(Depth - 1);

  state_t     state_q;
  state_t     state_d;
  logic [4:0] ptr;
  logic [4:0] end_idx;

  logic in_range;
  logic accept;
  logic reject;
  logic handshake;

  assign in_range  = ({1'b0, first} < DEPTH_CNT) && ({1'b0, last} < DEPTH_CNT);
  // abort outranks start in IDLE: neither an accept nor an err results.
  assign accept    = (state_q == S_IDLE) && start && !abort && in_range;
  assign reject    = (state_q == S_IDLE) && start && !abort && !in_range;
  assign handshake = m_valid && m_ready;

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over the handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_LOAD;
      S_LOAD: state_d = abort ? S_IDLE : S_SEND;
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (handshake) begin
          state_d = m_last ? S_DONE : S_LOAD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state, so rf_addr never glitches
  // on input activity.
  always_comb begin
    rf_addr = (state_q == S_LOAD) ? ptr : 5'd0;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
  end

  // Range pointers, output word register and the err pulse.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ptr     <= '0;
      end_idx <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_index <= '0;
      m_last  <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= reject;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            ptr     <= first;
            end_idx <= last;
          end
        end
        S_LOAD: begin
          // rf_data is combinational on rf_addr=ptr, so capture it right here.
          if (!abort) begin
            m_data  <= rf_data;
            m_index <= ptr;
            m_last  <= (ptr == end_idx);
            m_valid <= 1'b1;
          end
        end
        S_SEND: begin
          if (abort) begin
            m_valid <= 1'b0;
          end else if (handshake) begin
            m_valid <= 1'b0;
            if (!m_last) begin
              ptr <= (ptr == TOP_IDX) ? 5'd0 : ptr + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

  logic        CLK;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  first;
  logic [4:0]  last;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [4:0]  m_index;
  logic        m_last;
  logic        busy;
  logic        done;
  logic        err;

  // Second instance with a 16-entry register file for range-rejection checks.
  logic        start_b;
  logic [4:0]  first_b;
  logic [4:0]  last_b;
  logic [4:0]  rf_addr_b;
  logic [31:0] rf_data_b;
  logic        m_valid_b;
  logic [31:0] m_data_b;
  logic [4:0]  m_index_b;
  logic        m_last_b;
  logic        busy_b;
  logic        done_b;
  logic        err_b;

  logic [31:0] rf [32];

  int n_cmp;
  int n_err;

  assign rf_data   = rf[rf_addr];
  assign rf_data_b = rf[rf_addr_b];

  regfile_dump #(.Depth(32), .Width(32)) u_dut (
    .CLK(CLK), .reset(reset), .start(start), .abort(abort),
    .first(first), .last(last), .rf_addr(rf_addr), .rf_data(rf_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .busy(busy), .done(done), .err(err)
  );

  regfile_dump #(.Depth(16), .Width(32)) u_dut16 (
    .CLK(CLK), .reset(reset), .start(start_b), .abort(abort),
    .first(first_b), .last(last_b), .rf_addr(rf_addr_b), .rf_data(rf_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_index(m_index_b),
    .m_last(m_last_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Runs one dump on the 32-deep instance and checks it against the model:
  // word k of the dump is register (f+k) mod 32, count ((l-f+32) mod 32)+1.
  // mode 0: ready always 1; 1: ready toggles every 3 cycles; 2: random ready.
  // poke: issue a second start while busy, which must be ignored.
  task automatic do_dump(input int f, input int l, input int mode, input bit poke, input string tag);
    int          n_exp;
    int          k;
    int          hs_k;
    int          busy_cnt;
    int          lat;
    bit          pv;
    bit          pr;
    logic [31:0] pd;
    logic [4:0]  pi;
    logic        pl;
    int          got_idx[$];
    logic [31:0] got_dat[$];
    logic        got_last[$];
    bit          exp_done;
    int          idx;

    n_exp = ((l - f + 32) % 32) + 1;
    hs_k = -1; busy_cnt = 0; lat = -1; pv = 0; pr = 0;
    pd = '0; pi = '0; pl = 1'b0;
    @(negedge CLK);
    start = 1'b1; first = 5'(f); last = 5'(l); m_ready = (mode == 0);
    @(negedge CLK);
    start = 1'b0;
    k = 1;
    while (k < 400) begin
      if (busy) busy_cnt++;
      if (m_valid && lat < 0) lat = k;
      if (pv && !pr) begin
        n_cmp++;
        if (!(m_valid === 1'b1 && m_data === pd && m_index === pi && m_last === pl)) begin
          n_err++;
          $display("FAIL %s stall_hold k=%0d: got v=%b d=%h i=%0d l=%b, want v=1 d=%h i=%0d l=%b",
                   tag, k, m_valid, m_data, m_index, m_last, pd, pi, pl);
        end
      end
      exp_done = (hs_k >= 0) && (k == hs_k + 1);
      n_cmp++;
      if (done !== exp_done || err !== 1'b0) begin
        n_err++;
        $display("FAIL %s done_err k=%0d: got done=%b err=%b, want done=%b err=0", tag, k, done, err, exp_done);
      end
      if (!busy) break;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((k / 3) % 2) == 1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      start = poke && (k == 3);
      if (poke && k == 3) begin
        first = 5'(f + 1); last = 5'(f + 1);
      end
      if (m_valid && m_ready) begin
        got_idx.push_back(int'(m_index));
        got_dat.push_back(m_data);
        got_last.push_back(m_last);
        if (m_last) hs_k = k;
      end
      pv = m_valid; pr = m_ready; pd = m_data; pi = m_index; pl = m_last;
      @(negedge CLK);
      k++;
    end
    start = 1'b0;
    if (k >= 400) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: got busy=%b after %0d cycles, want 0", tag, busy, k);
    end
    n_cmp++;
    if (lat != 2) begin
      n_err++;
      $display("FAIL %s latency: got %0d, want 2", tag, lat);
    end
    if (mode == 0) begin
      n_cmp++;
      if (busy_cnt != 2 * n_exp + 1) begin
        n_err++;
        $display("FAIL %s busy_cycles: got %0d, want %0d", tag, busy_cnt, 2 * n_exp + 1);
      end
    end
    n_cmp++;
    if (got_idx.size() != n_exp) begin
      n_err++;
      $display("FAIL %s word_count: got %0d, want %0d", tag, got_idx.size(), n_exp);
    end
    for (int w = 0; w < n_exp && w < got_idx.size(); w++) begin
      idx = (f + w) % 32;
      n_cmp++;
      if (got_idx[w] != idx || got_dat[w] !== rf[idx] || got_last[w] !== (w == n_exp - 1)) begin
        n_err++;
        $display("FAIL %s word%0d: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                 tag, w, got_idx[w], got_dat[w], got_last[w], idx, rf[idx], (w == n_exp - 1));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({rf_addr, m_valid, m_data, m_index, m_last, busy, done, err} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got addr=%0d v=%b d=%h i=%0d l=%b busy=%b done=%b err=%b, want all 0",
               rf_addr, m_valid, m_data, m_index, m_last, busy, done, err);
    end
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({busy, m_valid, done, err, busy_b, m_valid_b} !== '0) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b v=%b done=%b err=%b, want 0", busy, m_valid, done, err);
    end
  endtask

  task automatic test_directed();
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + 32'(i);
    do_dump(3, 6, 0, 0, "range_3_6");
    do_dump(30, 1, 0, 0, "wrap_30_1");
    do_dump(9, 9, 0, 0, "single_9");
    do_dump(0, 7, 1, 0, "toggle_ready");
    do_dump(5, 4, 0, 0, "full_ring");
    do_dump(12, 15, 0, 1, "start_while_busy");
  endtask

  task automatic test_abort();
    int words;
    int t;
    @(negedge CLK);
    start = 1'b1; first = 5'd0; last = 5'd7; m_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    words = 0;
    for (t = 0; t < 50; t++) begin
      if (m_valid) begin
        if (words == 2) break;
        words++;
      end
      @(negedge CLK);
    end
    n_cmp++;
    if (m_valid !== 1'b1 || m_index !== 5'd2) begin
      n_err++;
      $display("FAIL abort_reach_word3: got v=%b idx=%0d, want v=1 idx=2", m_valid, m_index);
    end
    abort = 1'b1; m_ready = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if ({m_valid, busy, done} !== 3'b000) begin
        n_err++;
        $display("FAIL abort_after%0d: got v=%b busy=%b done=%b, want 0 0 0", c, m_valid, busy, done);
      end
      @(negedge CLK);
    end
    // abort together with start in IDLE: the start is dropped.
    abort = 1'b1; start = 1'b1; first = 5'd2; last = 5'd3;
    @(negedge CLK);
    abort = 1'b0; start = 1'b0;
    n_cmp++;
    if ({busy, err} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_with_start: got busy=%b err=%b, want 0 0", busy, err);
    end
    do_dump(0, 1, 0, 0, "after_abort");
  endtask

  task automatic test_range_err();
    int t;
    @(negedge CLK);
    start_b = 1'b1; first_b = 5'd20; last_b = 5'd3;
    @(negedge CLK);
    start_b = 1'b0;
    n_cmp++;
    if ({err_b, busy_b, m_valid_b} !== 3'b100) begin
      n_err++;
      $display("FAIL err_first20: got err=%b busy=%b v=%b, want 1 0 0", err_b, busy_b, m_valid_b);
    end
    @(negedge CLK);
    n_cmp++;
    if ({err_b, busy_b} !== 2'b00) begin
      n_err++;
      $display("FAIL err_one_cycle: got err=%b busy=%b, want 0 0", err_b, busy_b);
    end
    start_b = 1'b1; first_b = 5'd2; last_b = 5'd16;
    @(negedge CLK);
    start_b = 1'b0;
    n_cmp++;
    if ({err_b, busy_b} !== 2'b10) begin
      n_err++;
      $display("FAIL err_last16: got err=%b busy=%b, want 1 0", err_b, busy_b);
    end
    // Edge of range on the 16-deep instance: 15 wraps to 0.
    start_b = 1'b1; first_b = 5'd15; last_b = 5'd0; m_ready = 1'b1;
    @(negedge CLK);
    start_b = 1'b0;
    n_cmp++;
    if ({err_b, busy_b} !== 2'b01 || rf_addr_b !== 5'd15) begin
      n_err++;
      $display("FAIL accept_15_0: got err=%b busy=%b addr=%0d, want 0 1 15", err_b, busy_b, rf_addr_b);
    end
    @(negedge CLK); @(negedge CLK);
    n_cmp++;
    if (rf_addr_b !== 5'd0) begin
      n_err++;
      $display("FAIL wrap16_addr: got %0d, want 0", rf_addr_b);
    end
    for (t = 0; t < 20 && busy_b; t++) @(negedge CLK);
    n_cmp++;
    if (busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL wrap16_finish: got busy=%b, want 0", busy_b);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    start = 1'b1; first = 5'd4; last = 5'd10; m_ready = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (m_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_pre: got v=%b, want 1", m_valid);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({rf_addr, m_valid, m_data, m_index, m_last, busy, done, err} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_async: got v=%b d=%h i=%0d l=%b busy=%b, want all 0",
               m_valid, m_data, m_index, m_last, busy);
    end
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if ({busy, done, m_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mid_after: got busy=%b done=%b v=%b, want 0", busy, done, m_valid);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      do_dump($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 2),
              1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    start = 1'b0; abort = 1'b0; first = '0; last = '0; m_ready = 1'b0;
    start_b = 1'b0; first_b = '0; last_b = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + 32'(i);
    test_reset();
    test_directed();
    test_abort();
    test_range_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
